sdma_wport_ctrl: RTL and testbench
==================================

SDMA_WPORT_CTRL -- requirements
Module: sdma_wport_ctrl

Interface
REQ-001 SHALL have parameter LENW, default 16, beat-count width of instruction length.
REQ-002 SHALL take data width from `SDMA_CACHEDATAWIDTH and port-id width from `SDMA_INST_DSTPORTIDWIDTH (3).
REQ-003 SHALL use one clock and an asynchronous, active-high reset: i_clk input 1, rising-edge clock; i_rst input 1, async active-high reset.
REQ-004 SHALL have the instruction ports:
- i_inst_valid input 1: instruction offered.
- o_inst_ready output 1: controller can accept an instruction.
- i_inst_dstportid input 3: destination port.
- i_inst_len input LENW: beats to write.
REQ-005 SHALL have the source FIFO ports:
- i_fifo_rdata input CACHEDATAWIDTH: show-ahead head word.
- i_fifo_empty input 1: FIFO empty.
- o_fifo_rd output 1: pop the head word.
REQ-006 SHALL have the destination write-mux ports:
- o_inst_dstportid output 3: latched destination, drives the write-data mux select.
- o_sdma_dportwdata output CACHEDATAWIDTH: beat data to the mux.
REQ-007 SHALL have the per-port handshake ports:
- o_ahb_we, o_dc1_we, o_dc2_we, o_wc1_we, o_wc2_we: outputs, 1 bit each, beat strobes.
- i_ahb_wready, i_dc1_wready, i_dc2_wready, i_wc1_wready, i_wc2_wready: inputs, 1 bit each, port accepts a beat.
REQ-008 SHALL have the status outputs:
- o_wr_done output 1: one-cycle pulse, instruction complete.
- o_wr_err output 1: one-cycle pulse, instruction rejected or aborted.
- o_busy output 1: not in IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, XFER, DONE and ERR.
REQ-010 SHALL assert o_inst_ready only in IDLE; an instruction is accepted when i_inst_valid && o_inst_ready.
REQ-011 On accept, SHALL latch the port id into o_inst_dstportid and the length into the remaining-beat counter.
REQ-012 On accept, SHALL select the next state:
- legal port (000, 100, 101, 110, 111) with len>0: XFER.
- legal port with len==0: DONE, with no beats issued.
- illegal port (001, 010, 011): ERR, with no beats issued.
REQ-013 In XFER, a beat SHALL fire in any cycle where !i_fifo_empty and the selected port's wready are both high; in that cycle o_fifo_rd=1 and exactly the selected port's we=1.
REQ-014 o_sdma_dportwdata SHALL equal i_fifo_rdata combinationally (zero latency); it SHALL be all zeros when no beat fires.
REQ-015 Every fired beat SHALL decrement the counter by 1; the beat that takes the counter from 1 to 0 SHALL move the FSM to DONE.
REQ-016 FIFO empty or port not ready SHALL stall XFER with no strobes and the counter held; there is no drop and no duplicate.
REQ-017 DONE SHALL assert o_wr_done for one cycle, then go to IDLE; ERR SHALL assert o_wr_err for one cycle, then go to IDLE.
REQ-018 o_inst_dstportid SHALL hold its value through DONE and ERR, and SHALL change only on accept.
REQ-019 The counter SHALL never wrap; a length of 2^LENW-1 SHALL be supported.
REQ-020 o_fifo_rd and all we strobes SHALL be 0 outside XFER.

Reset
REQ-021 Reset SHALL put the FSM in IDLE, set the counter to 0 and o_inst_dstportid to 000, and hold all strobes, o_wr_done, o_wr_err and o_busy at 0; o_inst_ready SHALL be 1 once reset deasserts.
REQ-022 Reset mid-XFER SHALL abort immediately: no done or err pulse, no further beats, and the instruction is lost.

Configuration
REQ-023 Macro SDMA_WPORT_TIMEOUT_EN SHALL control the stall watchdog as follows:
- Defined: an 8-bit watchdog counts consecutive XFER stall cycles where the FIFO is non-empty and the port is not ready; it clears on any beat. When it reaches 255, the FSM goes to ERR (pulse o_wr_err) and the remaining beats are abandoned.
- Undefined: there is no watchdog and stalls are unbounded.

Structure
REQ-024 The shared package/header SHALL hold:
- port-id constants PORT_AHB=000, PORT_DC1=100, PORT_DC2=101, PORT_WC1=110, PORT_WC2=111;
- the FSM state encoding;
- the default watchdog limit of 255.
REQ-025 Sub-module sdma_wport_sel SHALL be used: combinational port decode producing the selected-ready signal, the one-hot we vector and the legal-port flag.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Port 100, len 4, FIFO full, dc1 ready always: 4 consecutive o_dc1_we/o_fifo_rd, then o_wr_done exactly 1 cycle after the 4th beat; other we stay 0.
- Port 000, len 3, i_ahb_wready toggling 1,0,1,0,1: exactly 3 beats in order, data matches the FIFO sequence, then done.
- Port 010, len 5: no strobes, o_wr_err pulses 1 cycle, o_inst_ready returns the next cycle.
- Port 111, len 0: no strobes, o_wr_done pulses once.
- Port 101, len 8, i_rst asserted after beat 3: all outputs 0 asynchronously, no done or err pulse, IDLE after release.
- With SDMA_WPORT_TIMEOUT_EN, port 110 never ready, FIFO non-empty: o_wr_err after 255 stall cycles, zero beats.

Source files
------------

// File: rtl/sdma_wport_ctrl_pkg.sv
// Shared definitions for the SDMA write-port controller.
//   - Destination port-id codes for the five write ports
//   - FSM state type used by sdma_wport_ctrl
//   - Default stall-watchdog limit (used when SDMA_WPORT_TIMEOUT_EN is defined)
// Widths come from `SDMA_CACHEDATAWIDTH and `SDMA_INST_DSTPORTIDWIDTH.
// Each macro gets a fallback value if the build does not supply it.
`ifndef SDMA_CACHEDATAWIDTH
`define SDMA_CACHEDATAWIDTH 32
`endif
`ifndef SDMA_INST_DSTPORTIDWIDTH
`define SDMA_INST_DSTPORTIDWIDTH 3
`endif

package sdma_wport_ctrl_pkg;

  localparam int unsigned DW     = `SDMA_CACHEDATAWIDTH;
  localparam int unsigned PIDW   = `SDMA_INST_DSTPORTIDWIDTH;
  localparam int unsigned NPORTS = 5;

  localparam logic [PIDW-1:0] PORT_AHB = 3'b000;
  localparam logic [PIDW-1:0] PORT_DC1 = 3'b100;
  localparam logic [PIDW-1:0] PORT_DC2 = 3'b101;
  localparam logic [PIDW-1:0] PORT_WC1 = 3'b110;
  localparam logic [PIDW-1:0] PORT_WC2 = 3'b111;

  localparam logic [7:0] WDOG_LIMIT = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } wport_state_e;

endpackage

// File: rtl/sdma_wport_sel.sv
// Combinational destination-port decode.
//   port_id   : destination port id
//   wready    : per-port ready, bit order {wc2, wc1, dc2, dc1, ahb}
//   sel_ready : ready of the decoded port (0 for an illegal id)
//   we_sel    : one-hot port select, same bit order as wready (0 for an illegal id)
//   legal     : port id is one of the five defined ports
module sdma_wport_sel
  import sdma_wport_ctrl_pkg::*;
(
  input  logic [PIDW-1:0]   port_id,
  input  logic [NPORTS-1:0] wready,
  output logic              sel_ready,
  output logic [NPORTS-1:0] we_sel,
  output logic              legal
);

  always_comb begin
    we_sel = '0;
    legal  = 1'b1;
    case (port_id)
      PORT_AHB: we_sel[0] = 1'b1;
      PORT_DC1: we_sel[1] = 1'b1;
      PORT_DC2: we_sel[2] = 1'b1;
      PORT_WC1: we_sel[3] = 1'b1;
      PORT_WC2: we_sel[4] = 1'b1;
      default:  legal     = 1'b0;
    endcase
    sel_ready = |(we_sel & wready);
  end

endmodule

// File: rtl/sdma_wport_ctrl.sv
// SDMA write-port controller: takes one instruction (port, beat count), then
// moves that many words from a show-ahead FIFO to the selected write port.
// A beat fires when the FIFO is non-empty and the port is ready.
// Ports:
//   i_clk, i_rst                  clock, async active-high reset
//   i_inst_valid/o_inst_ready     instruction handshake (ready only in IDLE)
//   i_inst_dstportid, i_inst_len  destination port and beat count
//   i_fifo_rdata/empty, o_fifo_rd source FIFO (show-ahead)
//   o_inst_dstportid              latched destination (write-data mux select)
//   o_sdma_dportwdata             beat data (zero when no beat fires)
//   o_*_we / i_*_wready           per-port beat strobe / accept
//   o_wr_done, o_wr_err           one-cycle completion / reject-abort pulses
//   o_busy                        controller not idle
// Optional feature: define SDMA_WPORT_TIMEOUT_EN to enable an 8-bit stall
// watchdog that aborts a transfer whose port stays not-ready for 255 cycles.
`ifndef SDMA_CACHEDATAWIDTH
`define SDMA_CACHEDATAWIDTH 32
`endif
`ifndef SDMA_INST_DSTPORTIDWIDTH
`define SDMA_INST_DSTPORTIDWIDTH 3
`endif

module sdma_wport_ctrl
  import sdma_wport_ctrl_pkg::*;
#(
  parameter int unsigned LENW = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_inst_valid,
  output logic            o_inst_ready,
  input  logic [PIDW-1:0] i_inst_dstportid,
  input  logic [LENW-1:0] i_inst_len,
  input  logic [DW-1:0]   i_fifo_rdata,
  input  logic            i_fifo_empty,
  output logic            o_fifo_rd,
  output logic [PIDW-1:0] o_inst_dstportid,
  output logic [DW-1:0]   o_sdma_dportwdata,
  output logic            o_ahb_we,
  output logic            o_dc1_we,
  output logic            o_dc2_we,
  output logic            o_wc1_we,
  output logic            o_wc2_we,
  input  logic            i_ahb_wready,
  input  logic            i_dc1_wready,
  input  logic            i_dc2_wready,
  input  logic            i_wc1_wready,
  input  logic            i_wc2_wready,
  output logic            o_wr_done,
  output logic            o_wr_err,
  output logic            o_busy
);

  wport_state_e      state_q, state_d;
  logic [LENW-1:0]   cnt_q;
  logic [PIDW-1:0]   port_q;
  logic [NPORTS-1:0] wready;
  logic [NPORTS-1:0] we_sel;
  logic [NPORTS-1:0] we_unused;
  logic              sel_ready;
  logic              sel_legal_unused;
  logic              in_legal;
  logic              in_ready_unused;
  logic              accept;
  logic              fire;
  logic              wdog_trip;

  assign wready = {i_wc2_wready, i_wc1_wready, i_dc2_wready, i_dc1_wready, i_ahb_wready};

  // Decode of the latched port drives the beat strobes.
  sdma_wport_sel u_sel (
    .port_id   (port_q),
    .wready    (wready),
    .sel_ready (sel_ready),
    .we_sel    (we_sel),
    .legal     (sel_legal_unused)
  );

  // Decode of the incoming port only supplies the legality check at accept.
  sdma_wport_sel u_chk (
    .port_id   (i_inst_dstportid),
    .wready    (wready),
    .sel_ready (in_ready_unused),
    .we_sel    (we_unused),
    .legal     (in_legal)
  );

  assign accept = i_inst_valid && o_inst_ready;

`ifdef SDMA_WPORT_TIMEOUT_EN
  logic [7:0] wdog_q;
  logic       stall;

  // Only "data waiting, port refusing" counts; an empty FIFO is not a port fault.
  assign stall     = (state_q == ST_XFER) && !i_fifo_empty && !sel_ready;
  assign wdog_trip = stall && (wdog_q == WDOG_LIMIT - 8'd1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      wdog_q <= '0;
    else if (stall) wdog_q <= wdog_q + 8'd1;
    else            wdog_q <= '0;
  end
`else
  assign wdog_trip = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    o_inst_ready = 1'b0;
    o_wr_done    = 1'b0;
    o_wr_err     = 1'b0;
    fire         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_inst_ready = !i_rst;
        if (i_inst_valid && !i_rst) begin
          if (!in_legal)             state_d = ST_ERR;
          else if (i_inst_len == '0) state_d = ST_DONE;
          else                       state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        fire = !i_fifo_empty && sel_ready;
        if (fire && (cnt_q == LENW'(1))) state_d = ST_DONE;
        else if (wdog_trip)              state_d = ST_ERR;
      end
      ST_DONE: begin
        o_wr_done = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_ERR: begin
        o_wr_err = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      port_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q  <= i_inst_len;
        port_q <= i_inst_dstportid;
      end else if (fire) begin
        cnt_q <= cnt_q - LENW'(1);
      end
    end
  end

  assign o_fifo_rd         = fire;
  assign o_sdma_dportwdata = fire ? i_fifo_rdata : '0;
  assign o_ahb_we          = fire && we_sel[0];
  assign o_dc1_we          = fire && we_sel[1];
  assign o_dc2_we          = fire && we_sel[2];
  assign o_wc1_we          = fire && we_sel[3];
  assign o_wc2_we          = fire && we_sel[4];
  assign o_inst_dstportid  = port_q;
  assign o_busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdma_wport_ctrl.sv
// Self-checking bench for sdma_wport_ctrl: transaction-level model compared
// every cycle, plus literal per-scenario expectations.
`ifndef SDMA_CACHEDATAWIDTH
`define SDMA_CACHEDATAWIDTH 32
`endif

module tb_sdma_wport_ctrl;

  localparam int unsigned LENW = 16;
  localparam int unsigned DW   = `SDMA_CACHEDATAWIDTH;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_inst_valid = 1'b0;
  logic            o_inst_ready;
  logic [2:0]      i_inst_dstportid = '0;
  logic [LENW-1:0] i_inst_len = '0;
  logic [DW-1:0]   i_fifo_rdata;
  logic            i_fifo_empty;
  logic            o_fifo_rd;
  logic [2:0]      o_inst_dstportid;
  logic [DW-1:0]   o_sdma_dportwdata;
  logic            o_ahb_we, o_dc1_we, o_dc2_we, o_wc1_we, o_wc2_we;
  logic [4:0]      wr = '0; // {wc2, wc1, dc2, dc1, ahb}
  logic            o_wr_done, o_wr_err, o_busy;

  always #5 i_clk = ~i_clk;

  sdma_wport_ctrl #(.LENW(LENW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_inst_valid(i_inst_valid), .o_inst_ready(o_inst_ready),
    .i_inst_dstportid(i_inst_dstportid), .i_inst_len(i_inst_len),
    .i_fifo_rdata(i_fifo_rdata), .i_fifo_empty(i_fifo_empty), .o_fifo_rd(o_fifo_rd),
    .o_inst_dstportid(o_inst_dstportid), .o_sdma_dportwdata(o_sdma_dportwdata),
    .o_ahb_we(o_ahb_we), .o_dc1_we(o_dc1_we), .o_dc2_we(o_dc2_we),
    .o_wc1_we(o_wc1_we), .o_wc2_we(o_wc2_we),
    .i_ahb_wready(wr[0]), .i_dc1_wready(wr[1]), .i_dc2_wready(wr[2]),
    .i_wc1_wready(wr[3]), .i_wc2_wready(wr[4]),
    .o_wr_done(o_wr_done), .o_wr_err(o_wr_err), .o_busy(o_busy)
  );

  // ---------------- source FIFO (show-ahead) ----------------
  logic [DW-1:0] mem [0:63];
  int unsigned   wp = 0, rp = 0;
  logic          force_empty = 1'b0;
  logic          flush = 1'b0;

  assign i_fifo_empty = force_empty || (wp == rp);
  assign i_fifo_rdata = (wp != rp) ? mem[rp[5:0]] : '0;

  always @(posedge i_clk) begin
    if (flush)          rp <= wp;
    else if (o_fifo_rd) rp <= rp + 1;
  end

  // ---------------- bookkeeping ----------------
  int unsigned n_checks = 0, n_pass = 0;
  int unsigned n_beats = 0, n_done = 0, n_err = 0, n_we = 0, n_busy = 0, cyc = 0;
  int unsigned we_cnt [5] = '{0, 0, 0, 0, 0};
  int unsigned last_beat_cyc = 0, done_cyc = 0;
  logic [DW-1:0] beat_log [$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  always @(posedge i_clk) begin
    logic [4:0] wv;
    wv = {o_wc2_we, o_wc1_we, o_dc2_we, o_dc1_we, o_ahb_we};
    cyc     <= cyc + 1;
    n_beats <= n_beats + (o_fifo_rd ? 1 : 0);
    n_done  <= n_done + (o_wr_done ? 1 : 0);
    n_err   <= n_err + (o_wr_err ? 1 : 0);
    n_busy  <= n_busy + (o_busy ? 1 : 0);
    n_we    <= n_we + $countones(wv);
    for (int i = 0; i < 5; i++) if (wv[i]) we_cnt[i] <= we_cnt[i] + 1;
  end

  // ---------------- transaction-level model ----------------
  int unsigned m_rem = 0, m_stall = 0;
  bit          m_act = 0, m_pd = 0, m_pe = 0;
  logic [2:0]  m_port = '0;

  function automatic int pidx(input logic [2:0] p);
    case (p)
      3'b000:  return 0;
      3'b100:  return 1;
      3'b101:  return 2;
      3'b110:  return 3;
      3'b111:  return 4;
      default: return -1;
    endcase
  endfunction

  function automatic bit m_fire();
    int k;
    k = pidx(m_port);
    return m_act && !i_fifo_empty && (k >= 0) && wr[k];
  endfunction

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_act = 0; m_pd = 0; m_pe = 0; m_rem = 0; m_stall = 0; m_port = '0;
    end else if (m_pd || m_pe) begin
      m_pd = 0; m_pe = 0;
    end else if (m_act) begin
      if (m_fire()) begin
        m_rem--; m_stall = 0;
        if (m_rem == 0) begin m_act = 0; m_pd = 1; end
      end else if (!i_fifo_empty) begin
        m_stall++;
`ifdef SDMA_WPORT_TIMEOUT_EN
        if (m_stall == 255) begin m_act = 0; m_pe = 1; end
`endif
      end else begin
        m_stall = 0;
      end
    end else if (i_inst_valid) begin
      m_port = i_inst_dstportid;
      if (pidx(i_inst_dstportid) < 0) m_pe = 1;
      else if (i_inst_len == 0)       m_pd = 1;
      else begin m_act = 1; m_rem = i_inst_len; m_stall = 0; end
    end
  end

  always @(negedge i_clk) begin
    bit idle, f;
    logic [4:0] ew;
    idle = !m_act && !m_pd && !m_pe;
    f    = m_fire();
    ew   = '0;
    if (f) ew[pidx(m_port)] = 1'b1;
    chk("ready",   o_inst_ready, idle && !i_rst);
    chk("busy",    o_busy, !idle);
    chk("done",    o_wr_done, m_pd);
    chk("err",     o_wr_err, m_pe);
    chk("fifo_rd", o_fifo_rd, f);
    chk("we",      {o_wc2_we, o_wc1_we, o_dc2_we, o_dc1_we, o_ahb_we}, ew);
    chk("wdata",   o_sdma_dportwdata, f ? i_fifo_rdata : '0);
    chk("dstport", o_inst_dstportid, m_port);
    if (o_fifo_rd) begin beat_log.push_back(o_sdma_dportwdata); last_beat_cyc = cyc; end
    if (o_wr_done) done_cyc = cyc;
  end

  // ---------------- stimulus ----------------
  int unsigned b_beats, b_done, b_err, b_we, b_busy, b_log;
  int unsigned b_port [5];

  task automatic snap();
    b_beats = n_beats; b_done = n_done; b_err = n_err; b_we = n_we; b_busy = n_busy;
    b_log = beat_log.size();
    for (int i = 0; i < 5; i++) b_port[i] = we_cnt[i];
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wp[5:0]] = d;
    wp = wp + 1;
  endtask

  task automatic do_flush();
    flush = 1'b1; @(posedge i_clk); #1; flush = 1'b0;
  endtask

  task automatic issue(input logic [2:0] p, input logic [LENW-1:0] l);
    i_inst_dstportid = p; i_inst_len = l; i_inst_valid = 1'b1;
    @(posedge i_clk); #1;
    i_inst_valid = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned maxc);
    int unsigned k;
    k = 0;
    while (o_busy && k < maxc) begin @(posedge i_clk); #1; k++; end
    chk("wait_idle_bound", o_busy, 1'b0);
  endtask

  task automatic expect_counts(input string s, input int unsigned beats,
                               input int unsigned dn, input int unsigned er);
    chk({s, "_beats"}, n_beats - b_beats, beats);
    chk({s, "_strobes"}, n_we - b_we, beats);
    chk({s, "_done"}, n_done - b_done, dn);
    chk({s, "_err"}, n_err - b_err, er);
  endtask

  initial begin
    logic [4:0] pat;
    int unsigned g;

    // reset
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_wr_done, 1'b0);
    chk("rst_err", o_wr_err, 1'b0);
    chk("rst_rd", o_fifo_rd, 1'b0);
    chk("rst_port", o_inst_dstportid, 3'b000);
    i_rst = 1'b0;
    #1 chk("rst_ready_after", o_inst_ready, 1'b1);
    @(posedge i_clk); #1;

    // S1: port 100, len 4, FIFO full, dc1 always ready
    snap();
    for (int i = 0; i < 4; i++) push(DW'(32'h1000 + i));
    wr = 5'b00010;
    issue(3'b100, 16'd4);
    wait_idle(20);
    expect_counts("s1", 4, 1, 0);
    chk("s1_dc1_we", we_cnt[1] - b_port[1], 4);
    chk("s1_done_lat", done_cyc - last_beat_cyc, 1);
    for (int i = 0; i < 4; i++) chk("s1_data", beat_log[b_log + i], 64'(32'h1000 + i));
    wr = '0;

    // S2: port 000, len 3, ahb ready toggling 1,0,1,0,1
    snap();
    push(DW'(32'hA1)); push(DW'(32'hA2)); push(DW'(32'hA3));
    issue(3'b000, 16'd3);
    pat = 5'b10101;
    for (int i = 0; i < 5; i++) begin wr[0] = pat[i]; @(posedge i_clk); #1; end
    wr = '0;
    wait_idle(10);
    expect_counts("s2", 3, 1, 0);
    chk("s2_ahb_we", we_cnt[0] - b_port[0], 3);
    chk("s2_d0", beat_log[b_log + 0], 64'h A1);
    chk("s2_d1", beat_log[b_log + 1], 64'h A2);
    chk("s2_d2", beat_log[b_log + 2], 64'h A3);

    // S3: illegal port 010, len 5
    snap();
    push(DW'(32'hBEEF)); push(DW'(32'hCAFE));
    wr = 5'b11111;
    issue(3'b010, 16'd5);
    wait_idle(10);
    expect_counts("s3", 0, 0, 1);
    chk("s3_busy_cycles", n_busy - b_busy, 1);
    chk("s3_ready_back", o_inst_ready, 1'b1);
    chk("s3_port_held", o_inst_dstportid, 3'b010);

    // S4: port 111, len 0
    snap();
    issue(3'b111, 16'd0);
    wait_idle(10);
    expect_counts("s4", 0, 1, 0);
    chk("s4_busy_cycles", n_busy - b_busy, 1);
    wr = '0;
    do_flush();

    // S5: port 101, len 8, reset after the 3rd beat
    snap();
    for (int i = 0; i < 8; i++) push(DW'(32'h5000 + i));
    wr = 5'b00100;
    issue(3'b101, 16'd8);
    g = 0;
    while ((n_beats - b_beats) < 3 && g < 20) begin @(posedge i_clk); #1; g++; end
    chk("s5_reach_beat3", n_beats - b_beats, 3);
    #2 i_rst = 1'b1;
    #1;
    chk("s5_rst_we", o_dc2_we, 1'b0);
    chk("s5_rst_rd", o_fifo_rd, 1'b0);
    chk("s5_rst_busy", o_busy, 1'b0);
    chk("s5_rst_port", o_inst_dstportid, 3'b000);
    chk("s5_rst_wdata", o_sdma_dportwdata, '0);
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    expect_counts("s5", 3, 0, 0);
    chk("s5_idle_ready", o_inst_ready, 1'b1);
    wr = '0;
    do_flush();

    // S6: port 110 with the port never ready, FIFO non-empty
    snap();
    push(DW'(32'h6666));
    issue(3'b110, 16'd3);
`ifdef SDMA_WPORT_TIMEOUT_EN
    wait_idle(300);
    expect_counts("s6", 0, 0, 1);
    chk("s6_busy_cycles", n_busy - b_busy, 256);
`else
    repeat (300) @(posedge i_clk);
    #1;
    chk("s6_still_busy", o_busy, 1'b1);
    expect_counts("s6_stall", 0, 0, 0);
    push(DW'(32'h6667)); push(DW'(32'h6668));
    wr[3] = 1'b1;
    wait_idle(10);
    expect_counts("s6", 3, 1, 0);
    chk("s6_d0", beat_log[b_log + 0], 64'h6666);
    chk("s6_d2", beat_log[b_log + 2], 64'h6668);
`endif
    wr = '0;
    do_flush();

    // S7: port 110, len 2, FIFO empty for a while then available
    snap();
    force_empty = 1'b1;
    push(DW'(32'h7001)); push(DW'(32'h7002));
    wr[3] = 1'b1;
    issue(3'b110, 16'd2);
    repeat (4) @(posedge i_clk);
    #1;
    chk("s7_no_beats_empty", n_beats - b_beats, 0);
    force_empty = 1'b0;
    wait_idle(10);
    expect_counts("s7", 2, 1, 0);
    chk("s7_wc1_we", we_cnt[3] - b_port[3], 2);
    chk("s7_d1", beat_log[b_log + 1], 64'h7002);

    @(posedge i_clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
